// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the bus-based datapath. One microstep per
// clock: fetch (T0-T2), then T3-T7 execute steps chosen by the opcode latched
// from IR[31:27]. Every control output is registered and decoded from the
// next state plus the next latched opcode.
module control_unit #(
    parameter logic [4:0] ALU_ADD_OP    = 5'b00011,
    parameter bit         HALT_ON_UNDEF = 1'b0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        PCout, PCin, IncPC,
    output logic        MARin, MDRin, MDRout, MDRread, RAMwrite,
    output logic        IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi,
    output logic        HIin, LOin, HIout, LOout,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, RCout,
    output logic        CONin, InPortOut, OutPortIn
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b01111, OP_MUL = 5'b10000;
    localparam logic [4:0] OP_BR = 5'b10011, OP_JR = 5'b10100, OP_IN = 5'b10110;
    localparam logic [4:0] OP_OUT = 5'b10111, OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // One mask per control line; the bit positions match the output assigns below.
    localparam logic [27:0] M_PCOUT = 28'd1 << 0,  M_PCIN = 28'd1 << 1,  M_INCPC = 28'd1 << 2;
    localparam logic [27:0] M_MARIN = 28'd1 << 3,  M_MDRIN = 28'd1 << 4, M_MDROUT = 28'd1 << 5;
    localparam logic [27:0] M_MDRREAD = 28'd1 << 6, M_RAMWRITE = 28'd1 << 7, M_IRIN = 28'd1 << 8;
    localparam logic [27:0] M_RYIN = 28'd1 << 9,   M_RZINLO = 28'd1 << 10, M_RZINHI = 28'd1 << 11;
    localparam logic [27:0] M_RZOUTLO = 28'd1 << 12, M_RZOUTHI = 28'd1 << 13, M_HIIN = 28'd1 << 14;
    localparam logic [27:0] M_LOIN = 28'd1 << 15,  M_HIOUT = 28'd1 << 16, M_LOOUT = 28'd1 << 17;
    localparam logic [27:0] M_GRA = 28'd1 << 18,   M_GRB = 28'd1 << 19,   M_GRC = 28'd1 << 20;
    localparam logic [27:0] M_RIN = 28'd1 << 21,   M_ROUT = 28'd1 << 22,  M_BAOUT = 28'd1 << 23;
    localparam logic [27:0] M_RCOUT = 28'd1 << 24, M_CONIN = 28'd1 << 25, M_INPORTOUT = 28'd1 << 26;
    localparam logic [27:0] M_OUTPORTIN = 28'd1 << 27;

    state_t      state, state_n;
    logic [4:0]  op_q, op_n;
    logic [27:0] ctrl_q;
    logic [4:0]  alu_q, alu_n;
    logic        run_q, run_n;
    logic        ir_unused;

    // Only the opcode field of IR matters to the sequencer.
    assign ir_unused = ^ir[26:0];

    function automatic logic is_reg(input logic [4:0] op);
        return op inside {[5'd3:5'd11]};
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return op inside {[5'd12:5'd14]};
    endfunction

    function automatic logic is_negnot(input logic [4:0] op);
        return op inside {5'd17, 5'd18};
    endfunction

    function automatic logic is_undef(input logic [4:0] op);
        return op inside {5'd21, [5'd28:5'd31]};
    endfunction

    // Control word for step s of opcode op; cf only matters in the br T6 step.
    function automatic logic [27:0] decode(input state_t s, input logic [4:0] op, input logic cf);
        logic [27:0] c;
        c = '0;
        case (s)
            S_T0: c = M_PCOUT | M_MARIN | M_INCPC;
            S_T1: c = M_MDRREAD | M_MDRIN;
            S_T2: c = M_MDROUT | M_IRIN;
            S_T3: begin
                if (is_reg(op) || is_imm(op) || is_negnot(op)) c = M_GRB | M_ROUT | M_RYIN;
                else if (op == OP_MUL || op == OP_DIV)     c = M_GRA | M_ROUT | M_RYIN;
                else if (op inside {OP_LD, OP_LDI, OP_ST}) c = M_GRB | M_BAOUT | M_RYIN;
                else if (op == OP_BR)   c = M_GRA | M_ROUT | M_CONIN;
                else if (op == OP_JR)   c = M_GRA | M_ROUT | M_PCIN;
                else if (op == OP_IN)   c = M_INPORTOUT | M_GRA | M_RIN;
                else if (op == OP_OUT)  c = M_GRA | M_ROUT | M_OUTPORTIN;
                else if (op == OP_MFHI) c = M_HIOUT | M_GRA | M_RIN;
                else if (op == OP_MFLO) c = M_LOOUT | M_GRA | M_RIN;
            end
            S_T4: begin
                if (is_reg(op))                            c = M_GRC | M_ROUT | M_RZINLO;
                else if (is_imm(op))                       c = M_RCOUT | M_RZINLO;
                else if (is_negnot(op))                    c = M_GRB | M_ROUT | M_RZINLO;
                else if (op == OP_MUL || op == OP_DIV)     c = M_GRB | M_ROUT | M_RZINLO | M_RZINHI;
                else if (op inside {OP_LD, OP_LDI, OP_ST}) c = M_RCOUT | M_RZINLO;
                else if (op == OP_BR)                      c = M_PCOUT | M_RYIN;
            end
            S_T5: begin
                if (is_reg(op) || is_imm(op) || is_negnot(op) || op == OP_LDI)
                    c = M_RZOUTLO | M_GRA | M_RIN;
                else if (op == OP_MUL || op == OP_DIV) c = M_RZOUTLO | M_LOIN;
                else if (op == OP_LD || op == OP_ST)   c = M_RZOUTLO | M_MARIN;
                else if (op == OP_BR)                  c = M_RCOUT | M_RZINLO;
            end
            S_T6: begin
                if (op == OP_MUL || op == OP_DIV) c = M_RZOUTHI | M_HIIN;
                else if (op == OP_LD)             c = M_MDRREAD | M_MDRIN;
                else if (op == OP_ST)             c = M_GRA | M_ROUT | M_MDRIN;
                else if (op == OP_BR)             c = M_RZOUTLO | (cf ? M_PCIN : 28'd0);
            end
            S_T7: begin
                if (op == OP_LD)      c = M_MDROUT | M_GRA | M_RIN;
                else if (op == OP_ST) c = M_RAMWRITE;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-step sequencing; the opcode is captured only on the T2->T3 edge.
    always_comb begin
        state_n = state;
        op_n    = (state == S_T2) ? ir[31:27] : op_q;
        case (state)
            S_RST: state_n = S_T0;
            S_T0:  state_n = S_T1;
            S_T1:  state_n = S_T2;
            S_T2:  state_n = S_T3;
            S_T3: begin
                if (op_q == OP_HALT || (HALT_ON_UNDEF && is_undef(op_q))) state_n = S_HALT;
                else if (op_q inside {OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, 5'b11010}
                         || is_undef(op_q))                            state_n = S_T0;
                else                                                   state_n = S_T4;
            end
            S_T4:   state_n = S_T5;
            S_T5:   state_n = (op_q inside {OP_LD, OP_ST, OP_BR, OP_MUL, OP_DIV}) ? S_T6 : S_T0;
            S_T6:   state_n = (op_q inside {OP_LD, OP_ST}) ? S_T7 : S_T0;
            S_T7:   state_n = S_T0;
            S_HALT: state_n = S_HALT;
            default: state_n = S_RST;
        endcase
        run_n = !(state_n inside {S_RST, S_HALT});
        if (!run_n)
            alu_n = '0;
        else if (op_n inside {[5'd3:5'd18]})
            alu_n = op_n;
        else
            alu_n = ALU_ADD_OP;
    end

    // State, opcode latch and registered control word; clear forces everything idle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= S_RST;
            op_q   <= '0;
            ctrl_q <= '0;
            alu_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            state  <= state_n;
            op_q   <= op_n;
            ctrl_q <= decode(state_n, op_n, con_ff);
            alu_q  <= alu_n;
            run_q  <= run_n;
        end
    end

    assign alu_op    = alu_q;
    assign run       = run_q;
    assign PCout     = ctrl_q[0];
    assign PCin      = ctrl_q[1];
    assign IncPC     = ctrl_q[2];
    assign MARin     = ctrl_q[3];
    assign MDRin     = ctrl_q[4];
    assign MDRout    = ctrl_q[5];
    assign MDRread   = ctrl_q[6];
    assign RAMwrite  = ctrl_q[7];
    assign IRin      = ctrl_q[8];
    assign RYin      = ctrl_q[9];
    assign RZinLo    = ctrl_q[10];
    assign RZinHi    = ctrl_q[11];
    assign RZoutLo   = ctrl_q[12];
    assign RZoutHi   = ctrl_q[13];
    assign HIin      = ctrl_q[14];
    assign LOin      = ctrl_q[15];
    assign HIout     = ctrl_q[16];
    assign LOout     = ctrl_q[17];
    assign Gra       = ctrl_q[18];
    assign Grb       = ctrl_q[19];
    assign Grc       = ctrl_q[20];
    assign Rin       = ctrl_q[21];
    assign Rout      = ctrl_q[22];
    assign BAout     = ctrl_q[23];
    assign RCout     = ctrl_q[24];
    assign CONin     = ctrl_q[25];
    assign InPortOut = ctrl_q[26];
    assign OutPortIn = ctrl_q[27];

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore-style sequencer that drives every control input of the bus-based datapath, one microstep per clock.
- Steps fetch, decode and execute for the phase-3 instruction set, decoding the opcode at IR[31:27].
- Sits directly upstream of the datapath: its outputs wire 1:1 to the datapath control pins.
- Also supplies the ALU operation code. The datapath ALU Op input is rewired to alu_op.

Parameters:
ALU_ADD_OP, 5'b00011, ALU code driven for address and branch-target arithmetic.
HALT_ON_UNDEF, 0, 1 means an undefined opcode enters HALT; 0 means it executes as nop.

Ports:
clock  input  1  rising-edge clock
clear  input  1  asynchronous, active-low reset
ir  input  32  instruction register contents (opcode at [31:27])
con_ff  input  1  branch-condition flip-flop from the datapath
alu_op  output  5  ALU operation select
run  output  1  high while executing; low in RST and HALT
PCout, PCin, IncPC  output  1 each  program counter controls
MARin, MDRin, MDRout, MDRread, RAMwrite  output  1 each  memory path controls
IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi  output  1 each  IR, Y and Z controls
HIin, LOin, HIout, LOout  output  1 each  HI and LO controls
Gra, Grb, Grc, Rin, Rout, BAout, RCout  output  1 each  to select_and_encode
CONin, InPortOut, OutPortIn  output  1 each  condition and I/O controls

Behaviour:
- States: RST, T0–T7, HALT. All control outputs are decoded from the state register and the latched opcode only.
- Any step not listed below drives that control output to 0.
- clear low (asynchronous): state goes to RST, all outputs are 0, run=0, and this applies even mid-instruction. The first rising edge after clear goes high moves RST to T0.
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011. All other codes are undefined.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: MDRread, MDRin.
  - T2: MDRout, IRin.
- The opcode is latched from ir at the T2→T3 edge.
- alu_op rule: the latched opcode for the ALU class (add..ori, div, mul, neg, not); ALU_ADD_OP otherwise.
- Register ALU ops (add–shl): T3 Grb Rout RYin; T4 Grc Rout RZinLo; T5 RZoutLo Gra Rin. 6 cycles.
- Immediate ops (addi/andi/ori): same as register ALU ops, except T4 is RCout RZinLo.
- neg/not: same as register ALU ops, except T4 uses Grb instead of Grc.
- mul/div: T3 Gra Rout RYin; T4 Grb Rout RZinLo RZinHi; T5 RZoutLo LOin; T6 RZoutHi HIin. 7 cycles.
- ld: T3 Grb BAout RYin; T4 RCout RZinLo; T5 RZoutLo MARin; T6 MDRread MDRin; T7 MDRout Gra Rin. 8 cycles.
- ldi: ld steps T3–T4, then T5 RZoutLo Gra Rin. 6 cycles.
- st: ld steps T3–T5; T6 Gra Rout MDRin (MDRread=0); T7 RAMwrite. 8 cycles.
- br: T3 Gra Rout CONin; T4 PCout RYin; T5 RCout RZinLo; T6 RZoutLo, with PCin = con_ff as sampled in T6. 7 cycles.
- Single-step T3 instructions, all 4 cycles:
  - jr: Gra Rout PCin.
  - in: InPortOut Gra Rin.
  - out: Gra Rout OutPortIn.
  - mfhi: HIout Gra Rin.
  - mflo: LOout Gra Rin.
  - nop: no controls.
- halt: T3 goes to HALT. HALT holds with all outputs 0 and run=0 until clear.
- The last step of every instruction returns to T0 on the next edge. No two bus-driving outputs are ever high in the same step.
- ir changes after the T2→T3 edge have no effect until the next fetch.

Test Plan:
- Hold clear low for 3 cycles, then release → outputs 0 and run=0 during reset; first edge enters T0 with PCout=MARin=IncPC=1.
- ir=add R1,R2,R3 (0x18918000) → 6 cycles; T4 shows Grc Rout RZinLo with alu_op=00011; T5 shows RZoutLo Gra Rin; returns to T0.
- ld R1,0x54(R2) (0x00900054) → 8 cycles; T6 shows MDRread=MDRin=1; T7 shows MDRout Gra Rin.
- br (0x99000014), run twice with con_ff=1 then con_ff=0 → PCin=1 in T6 for the first run, 0 for the second; both last 7 cycles.
- mul R3,R4 (0x81A00000) → T5 shows RZoutLo LOin; T6 shows RZoutHi HIin.
- Pull clear low mid-ld in T5 → state goes to RST immediately and all outputs are 0.
- halt (0xD8000000) → HALT reached and run=0 holds across 20 cycles.
- Undefined opcode 11111 with HALT_ON_UNDEF=0 → executes as a 4-cycle nop.
